// File: rtl/case8_arb_pkg.sv
// Shared constants, slot state type and round-robin helper for the case8 arbiter.
package case8_arb_pkg;

    localparam int IN_W  = 10;
    localparam int OUT_W = 5;

    // Input bit positions: a is the MSB, j is the LSB.
    localparam int A_BIT = 9;
    localparam int B_BIT = 8;
    localparam int C_BIT = 7;
    localparam int D_BIT = 6;
    localparam int E_BIT = 5;
    localparam int F_BIT = 4;
    localparam int G_BIT = 3;
    localparam int H_BIT = 2;
    localparam int I_BIT = 1;
    localparam int J_BIT = 0;

    localparam int Y1_BIT = 4;
    localparam int Y2_BIT = 3;
    localparam int Y3_BIT = 2;
    localparam int Y4_BIT = 1;
    localparam int Y5_BIT = 0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    function automatic int unsigned next_rr(input int unsigned k, input int unsigned n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/case8_core.sv
// Purely combinational case8 evaluator: 10 input bits (a..j) to 5 result bits (y1..y5).
module case8_core
    import case8_arb_pkg::*;
(
    input  logic [IN_W-1:0]  in_vec,
    output logic [OUT_W-1:0] out_vec
);

    logic p, q, r;
    logic y1, y2, y3, y4, y5;

    assign p  = (in_vec[A_BIT] | in_vec[B_BIT]) & in_vec[C_BIT] & in_vec[D_BIT];
    assign q  = in_vec[I_BIT] & in_vec[J_BIT];
    assign r  = in_vec[G_BIT] | in_vec[H_BIT] | (in_vec[E_BIT] ^ in_vec[F_BIT]);

    assign y1 = p & (r | q);
    assign y2 = (p & ~r) | (r & q);
    assign y5 = p | (r & q);
    assign y3 = y5 & ~y1;
    assign y4 = y5 & (r | q);

    always_comb begin
        out_vec         = '0;
        out_vec[Y1_BIT] = y1;
        out_vec[Y2_BIT] = y2;
        out_vec[Y3_BIT] = y3;
        out_vec[Y4_BIT] = y4;
        out_vec[Y5_BIT] = y5;
    end

endmodule

// File: rtl/case8_arbiter.sv
// Round-robin sharing of one case8 core among NREQ requesters, with a one-entry output slot.
// Optional accept/y1 statistics counters are built when CASE8_STATS_EN is defined.
module case8_arbiter
    import case8_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IN_W-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [OUT_W-1:0]     rsp_data,
    output logic [IDW-1:0]       rsp_id,
    input  logic                 rsp_ready
`ifdef CASE8_STATS_EN
    ,
    output logic [15:0]          stat_acc,
    output logic [15:0]          stat_y1
`endif
);

    slot_state_e      state, next_state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win_idx;
    logic             win_found;
    logic             slot_free;
    logic             accept;
    logic [IN_W-1:0]  core_in;
    logic [OUT_W-1:0] core_out;

    // Search starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            int unsigned     cand;
            logic [IDW-1:0]  cand_idx;
            cand = 32'(ptr) + 32'(i);
            if (cand >= 32'(NREQ)) cand = cand - 32'(NREQ);
            cand_idx = IDW'(cand);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign slot_free = (state == EMPTY) | rsp_ready;
    assign accept    = win_found & slot_free & ~rst;
    assign req_ready = accept ? (NREQ'(1) << win_idx) : '0;
    assign rsp_valid = (state == FULL);
    assign core_in   = req_data[win_idx*IN_W +: IN_W];

    case8_core u_core (
        .in_vec  (core_in),
        .out_vec (core_out)
    );

    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   if (accept) next_state = FULL;
            FULL:    if (accept) next_state = FULL;
                     else if (rsp_ready) next_state = EMPTY;
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= EMPTY;
            rsp_data <= '0;
            rsp_id   <= '0;
            ptr      <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                rsp_data <= core_out;
                rsp_id   <= win_idx;
                ptr      <= IDW'(next_rr(32'(win_idx), 32'(NREQ)));
            end
        end
    end

`ifdef CASE8_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_acc <= '0;
            stat_y1  <= '0;
        end else if (accept) begin
            if (stat_acc != 16'hFFFF) stat_acc <= stat_acc + 16'd1;
            if (core_out[Y1_BIT] && stat_y1 != 16'hFFFF) stat_y1 <= stat_y1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_case8_arbiter.sv
// Self-checking bench for case8_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_case8_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*10-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic [4:0]          rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_ready;
`ifdef CASE8_STATS_EN
    logic [15:0]         stat_acc;
    logic [15:0]         stat_y1;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit         m_valid;
    logic [4:0] m_data;
    int         m_id;
    int         m_ptr;
    int         m_acc;
    int         m_y1;

    always #5 clk = ~clk;

    case8_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
`ifdef CASE8_STATS_EN
        ,
        .stat_acc  (stat_acc),
        .stat_y1   (stat_y1)
`endif
    );

    function automatic logic [4:0] ref_f(input logic [9:0] d);
        bit a, b, c, dd, e, f, g, h, i, j, p, q, r, y1, y2, y3, y4, y5;
        {a, b, c, dd, e, f, g, h, i, j} = d;
        p  = (a || b) && c && dd;
        q  = i && j;
        r  = g || h || (e != f);
        y1 = p && (r || q);
        y2 = (p && !r) || (r && q);
        y5 = p || (r && q);
        y3 = y5 && !y1;
        y4 = y5 && (r || q);
        return {y1, y2, y3, y4, y5};
    endfunction

    function automatic logic [9:0] field(input int k);
        return req_data[k*10 +: 10];
    endfunction

    // One clock cycle: inputs are already driven (just after negedge).
    task automatic step(input string tag);
        int         k;
        logic [3:0] exp_ready;
        k = -1;
        if (!rst && (!m_valid || rsp_ready)) begin
            for (int i = 0; i < NREQ; i++) begin
                int c;
                c = (m_ptr + i) % NREQ;
                if (k < 0 && req_valid[c]) k = c;
            end
        end
        exp_ready = (k >= 0) ? 4'(1 << k) : 4'b0000;
        #1;
        checks++;
        if (req_ready !== exp_ready) begin
            failures++;
            $display("FAIL %s req_ready got=%b exp=%b", tag, req_ready, exp_ready);
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0; m_acc = 0; m_y1 = 0;
        end else if (k >= 0) begin
            m_valid = 1;
            m_data  = ref_f(field(k));
            m_id    = k;
            m_ptr   = (k + 1) % NREQ;
            if (m_acc < 65535) m_acc++;
            if (m_data[4] && m_y1 < 65535) m_y1++;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== m_valid) begin
            failures++;
            $display("FAIL %s rsp_valid got=%b exp=%b", tag, rsp_valid, m_valid);
        end
        checks++;
        if (rsp_data !== m_data) begin
            failures++;
            $display("FAIL %s rsp_data got=%b exp=%b", tag, rsp_data, m_data);
        end
        checks++;
        if (rsp_id !== IDW'(m_id)) begin
            failures++;
            $display("FAIL %s rsp_id got=%0d exp=%0d", tag, rsp_id, m_id);
        end
`ifdef CASE8_STATS_EN
        checks++;
        if (stat_acc !== 16'(m_acc) || stat_y1 !== 16'(m_y1)) begin
            failures++;
            $display("FAIL %s stats got=%0d/%0d exp=%0d/%0d", tag, stat_acc, stat_y1, m_acc, m_y1);
        end
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        req_data  = {4{10'h2C8}};
        rsp_ready = 1'b1;
        rst       = 1'b1;
        step("reset_hold0");
        step("reset_hold1");
        rst = 1'b0;
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 5'b0 || rsp_id !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b/%b/%0d exp=0/00000/0", rsp_valid, rsp_data, rsp_id);
        end
    endtask

    task automatic test_single();
        logic [9:0] din  [4] = '{10'h2C0, 10'h000, 10'h00B, 10'h2C8};
        logic [4:0] dexp [4] = '{5'b01101, 5'b00000, 5'b01111, 5'b10011};
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001;
            req_data  = '0;
            req_data[9:0] = din[i];
            step("single");
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== dexp[i] || rsp_id !== 2'd0) begin
                failures++;
                $display("FAIL single_%0d got=%b/%b/%0d exp=1/%b/0", i, rsp_valid, rsp_data, rsp_id, dexp[i]);
            end
            req_valid = '0;
            step("single_drain");
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < NREQ; k++) req_data[k*10 +: 10] = 10'($urandom);
            step("rr");
            checks++;
            if (rsp_id !== IDW'(i % NREQ) || rsp_valid !== 1'b1) begin
                failures++;
                $display("FAIL rr_order_%0d got_id=%0d exp_id=%0d", i, rsp_id, i % NREQ);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] held;
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_data  = {10'h2C8, 10'h00B, 10'h000, 10'h2C0};
        step("bp_fill");
        held = rsp_data;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) step("bp_hold");
        checks++;
        if (rsp_data !== held || rsp_id !== 2'd0) begin
            failures++;
            $display("FAIL bp_stable got=%b/%0d exp=%b/0", rsp_data, rsp_id, held);
        end
        rsp_ready = 1'b1;
        step("bp_release");
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 5'b00000) begin
            failures++;
            $display("FAIL bp_release got=%b/%0d/%b exp=1/1/00000", rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rsp_ready = 1'b1;
        req_data  = {4{10'h00B}};
        req_valid = 4'b0010;
        step("wrap_setptr");
        req_valid = 4'b1001;
        step("wrap_first");
        checks++;
        if (rsp_id !== 2'd3) begin
            failures++;
            $display("FAIL wrap_first got=%0d exp=3", rsp_id);
        end
        step("wrap_second");
        checks++;
        if (rsp_id !== 2'd0) begin
            failures++;
            $display("FAIL wrap_second got=%0d exp=0", rsp_id);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_data  = {4{10'h2C8}};
        step("mid_fill0");
        step("mid_fill1");
        rsp_ready = 1'b0;
        rst = 1'b1;
        step("mid_rst");
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 5'b0 || rsp_id !== '0) begin
            failures++;
            $display("FAIL mid_reset got=%b/%b/%0d exp=0/00000/0", rsp_valid, rsp_data, rsp_id);
        end
        rsp_ready = 1'b1;
        step("mid_after");
        checks++;
        if (rsp_id !== 2'd0) begin
            failures++;
            $display("FAIL mid_ptr got=%0d exp=0", rsp_id);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            req_valid = 4'($urandom);
            req_data  = {10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom)};
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step("random");
        end
        rst = 1'b0;
    endtask

`ifdef CASE8_STATS_EN
    task automatic test_stats_saturate();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_data  = {4{10'h2C8}};
        repeat (70000) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stat_acc !== 16'hFFFF || stat_y1 !== 16'hFFFF) begin
            failures++;
            $display("FAIL stats_sat got=%h/%h exp=ffff/ffff", stat_acc, stat_y1);
        end
        m_valid = 1; m_data = 5'b10011; m_id = 3; m_ptr = 0; m_acc = 65535; m_y1 = 65535;
        rst = 1'b1;
        step("stats_clear");
        rst = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0; m_acc = 0; m_y1 = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef CASE8_STATS_EN
        test_stats_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
